diag_ebus_seq: RTL and testbench

DIAG_EBUS_SEQ -- requirements
Module: diag_ebus_seq

---
 rtl/diag_pkg.sv | 31 +++
 rtl/diag_func_decode.sv | 15 +
 rtl/diag_ebus_seq.sv | 158 +++++++++++++++
 tb/tb_diag_ebus_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diag_pkg.sv
// Shared types and constants for the diagnostic EBUS sequencer.
package diag_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RWAIT,
        CAPT,
        DONE,
        CPU
    } state_t;

    localparam int READ_WAIT_DEF = 4;

    // Group indices are the upper octal digit pair of the function code (reqFunc[0:3]).
    localparam int GRP_00X = 0;
    localparam int GRP_04X = 4;
    localparam int GRP_06X = 6;
    localparam int GRP_07X = 7;
    localparam int GRP_11X = 9;
    localparam int GRP_12X = 10;
    localparam int GRP_13X = 11;
    localparam int GRP_14X = 12;

    function automatic logic oddParity(input logic [35:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/diag_func_decode.sv
// One-hot decode of the function group (top four bits of the diagnostic code).
module diag_func_decode (
    input  logic [0:3]  i_grp,
    input  logic        i_en,
    output logic [15:0] o_grp
);

    always_comb begin
        o_grp = '0;
        if (i_en) begin
            o_grp[i_grp] = 1'b1;
        end
    end

endmodule

// File: rtl/diag_ebus_seq.sv
// Diagnostic function sequencer arbitrating the EBUS between diag requests and microcode transfers.
// Optional EBUS parity generation/checking is enabled with the EBUS_PARITY_EN macro.
module diag_ebus_seq
    import diag_pkg::*;
#(
    parameter int READ_WAIT = READ_WAIT_DEF
) (
    input  logic        clk,
    input  logic        CROBAR,
    input  logic        req,
    input  logic [0:6]  reqFunc,
    input  logic [35:0] reqWdata,
    output logic        reqAck,
    output logic        done,
    output logic [35:0] rdata,
    output logic        rdErr,
    input  logic        cpuXferReq,
    output logic        cpuXferGnt,
    output logic [0:6]  DIAG_DIAG,
    output logic [15:0] funcGrp,
    output logic        DIAG_STROBE,
    output logic        DIAG_READ,
    output logic        EBUS_XFER,
    output logic        EBUS_T_TO_E_EN,
    output logic        EBUS_E_TO_T_EN,
    output logic [35:0] ebusDataOut,
    input  logic [35:0] ebusDataIn,
    output logic        EBUS_PARITY_OUT,
    input  logic        ebusParityIn
);

    state_t      r_state;
    state_t      w_next;
    logic [0:6]  r_func;
    logic [35:0] r_wdata;
    logic [35:0] r_rdata;
    logic [3:0]  r_cnt;
    logic        r_fair;
    logic        r_done;
    logic        r_strobe;
    logic        r_read;
    logic        r_xfer;
    logic        r_tToE;
    logic        r_gnt;
    logic        r_valid;
    logic        r_drive;
    logic        w_accept;
    logic        w_nextRead;

    // A CPU request displaces a diag request unless the diag side is owed a turn.
    assign w_accept   = (r_state == IDLE) && req && (!cpuXferReq || r_fair) && !CROBAR;
    assign w_nextRead = w_accept ? reqFunc[0] : r_func[0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = SETUP;
                end else if (cpuXferReq) begin
                    w_next = CPU;
                end
            end
            SETUP:   w_next = r_func[0] ? RWAIT : STROBE;
            STROBE:  w_next = HOLD;
            HOLD:    w_next = DONE;
            RWAIT:   w_next = (r_cnt == 4'd0) ? CAPT : RWAIT;
            CAPT:    w_next = DONE;
            DONE:    w_next = IDLE;
            CPU:     w_next = cpuXferReq ? CPU : IDLE;
            default: w_next = IDLE;
        endcase
    end

`ifdef EBUS_PARITY_EN
    logic r_rdErr;
`endif

    // Outputs are registered from the next state so they change cleanly on the clock edge.
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            r_state  <= IDLE;
            r_func   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
            r_fair   <= 1'b0;
            r_done   <= 1'b0;
            r_strobe <= 1'b0;
            r_read   <= 1'b0;
            r_xfer   <= 1'b0;
            r_tToE   <= 1'b0;
            r_gnt    <= 1'b0;
            r_valid  <= 1'b0;
            r_drive  <= 1'b0;
`ifdef EBUS_PARITY_EN
            r_rdErr  <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_func  <= reqFunc;
                r_wdata <= reqWdata;
                r_fair  <= 1'b0;
            end else if (r_state == CPU && w_next == IDLE) begin
                r_fair  <= 1'b1;
            end
            if (r_state == SETUP) begin
                r_cnt <= 4'(READ_WAIT - 1);
            end else if (r_state == RWAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == CAPT) begin
                r_rdata <= ebusDataIn;
`ifdef EBUS_PARITY_EN
                r_rdErr <= (ebusParityIn != oddParity(ebusDataIn));
`endif
            end
            r_gnt    <= (w_next == CPU);
            r_strobe <= (w_next == STROBE);
            r_done   <= (w_next == DONE);
            r_valid  <= (w_next inside {SETUP, STROBE, HOLD, RWAIT, CAPT, DONE});
            r_xfer   <= (w_next inside {SETUP, STROBE, HOLD, RWAIT, CAPT, CPU});
            r_drive  <= !w_nextRead && (w_next inside {SETUP, STROBE, HOLD});
            r_tToE   <= (w_next == CPU) || (!w_nextRead && (w_next inside {SETUP, STROBE, HOLD}));
            r_read   <= w_nextRead && (w_next inside {SETUP, RWAIT, CAPT});
        end
    end

    diag_func_decode u_decode (
        .i_grp (r_func[0:3]),
        .i_en  (r_valid),
        .o_grp (funcGrp)
    );

    assign reqAck         = w_accept;
    assign done           = r_done;
    assign rdata          = r_rdata;
    assign cpuXferGnt     = r_gnt;
    assign DIAG_DIAG      = r_valid ? r_func : '0;
    assign DIAG_STROBE    = r_strobe;
    assign DIAG_READ      = r_read;
    assign EBUS_XFER      = r_xfer;
    assign EBUS_T_TO_E_EN = r_tToE;
    assign EBUS_E_TO_T_EN = r_read;
    assign ebusDataOut    = r_drive ? r_wdata : '0;

`ifdef EBUS_PARITY_EN
    assign rdErr           = r_rdErr;
    assign EBUS_PARITY_OUT = r_tToE ? oddParity(ebusDataOut) : 1'b0;
`else
    logic w_unusedParity;
    assign w_unusedParity  = ebusParityIn;
    assign rdErr           = 1'b0;
    assign EBUS_PARITY_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_diag_ebus_seq.sv
// Self-checking bench for diag_ebus_seq; honours EBUS_PARITY_EN when the build defines it.
module tb_diag_ebus_seq;

    localparam int RW = 4;

    logic        clk;
    logic        CROBAR;
    logic        req;
    logic [0:6]  reqFunc;
    logic [35:0] reqWdata;
    logic        reqAck;
    logic        done;
    logic [35:0] rdata;
    logic        rdErr;
    logic        cpuXferReq;
    logic        cpuXferGnt;
    logic [0:6]  DIAG_DIAG;
    logic [15:0] funcGrp;
    logic        DIAG_STROBE;
    logic        DIAG_READ;
    logic        EBUS_XFER;
    logic        EBUS_T_TO_E_EN;
    logic        EBUS_E_TO_T_EN;
    logic [35:0] ebusDataOut;
    logic [35:0] ebusDataIn;
    logic        EBUS_PARITY_OUT;
    logic        ebusParityIn;

    int vectors = 0;
    int miscompares = 0;

    // Model state: mMode 0 = idle, 1 = CPU transfer, 2 = diag sequence (mK = cycles since accept)
    int          mMode, mK;
    logic        mRead, mFair, mRdErr;
    logic [0:6]  mFunc;
    logic [35:0] mData, mRdata;

    // Event log written only by the compare process
    int          cycleNo = 0;
    int          ackCount = 0, doneCount = 0, strobeCount = 0, readHigh = 0, gntCount = 0;
    int          lastAckCyc = -10, lastDoneCyc = -10, lastStrobeCyc = -10;
    logic [15:0] grpAtSetup;
    logic [35:0] doutAtSetup;

    int          lastDropCyc = -10;

    diag_ebus_seq #(.READ_WAIT(RW)) dut (
        .clk             (clk),
        .CROBAR          (CROBAR),
        .req             (req),
        .reqFunc         (reqFunc),
        .reqWdata        (reqWdata),
        .reqAck          (reqAck),
        .done            (done),
        .rdata           (rdata),
        .rdErr           (rdErr),
        .cpuXferReq      (cpuXferReq),
        .cpuXferGnt      (cpuXferGnt),
        .DIAG_DIAG       (DIAG_DIAG),
        .funcGrp         (funcGrp),
        .DIAG_STROBE     (DIAG_STROBE),
        .DIAG_READ       (DIAG_READ),
        .EBUS_XFER       (EBUS_XFER),
        .EBUS_T_TO_E_EN  (EBUS_T_TO_E_EN),
        .EBUS_E_TO_T_EN  (EBUS_E_TO_T_EN),
        .ebusDataOut     (ebusDataOut),
        .ebusDataIn      (ebusDataIn),
        .EBUS_PARITY_OUT (EBUS_PARITY_OUT),
        .ebusParityIn    (ebusParityIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleNo);
        end
    endtask

    function automatic logic expParity(input logic [35:0] d);
        return ~^d;
    endfunction

    // Per-cycle comparison against the transaction-level model, sampled on the falling edge
    initial begin : compareProc
        int          len;
        logic        eAck, eDone, eStrobe, eRead, eXfer, eTtoE, eGnt, ePar;
        logic [0:6]  eDiag;
        logic [15:0] eGrp;
        logic [35:0] eDout;
        mMode = 0; mK = 0; mRead = 0; mFair = 0; mRdErr = 0; mFunc = '0; mData = '0; mRdata = '0;
        forever begin
            @(negedge clk);
            cycleNo++;
            eAck = 0; eDone = 0; eStrobe = 0; eRead = 0; eXfer = 0; eTtoE = 0; eGnt = 0;
            eDiag = '0; eGrp = '0; eDout = '0;
            if (!CROBAR) begin
                case (mMode)
                    0: eAck = req && (!cpuXferReq || mFair);
                    1: begin eGnt = 1; eXfer = 1; eTtoE = 1; end
                    default: begin
                        eDiag = mFunc;
                        eGrp  = 16'd1 << mFunc[0:3];
                        if (mRead) begin
                            eRead = (mK <= RW + 2);
                            eXfer = eRead;
                            eDone = (mK == RW + 3);
                        end else begin
                            eTtoE   = (mK <= 3);
                            eXfer   = eTtoE;
                            eDout   = eTtoE ? mData : '0;
                            eStrobe = (mK == 2);
                            eDone   = (mK == 4);
                        end
                    end
                endcase
            end
`ifdef EBUS_PARITY_EN
            ePar = eTtoE ? expParity(eDout) : 1'b0;
`else
            ePar = 1'b0;
`endif
            checkOutput("reqAck", reqAck, eAck);
            checkOutput("done", done, eDone);
            checkOutput("rdata", rdata, CROBAR ? 36'd0 : mRdata);
            checkOutput("rdErr", rdErr, CROBAR ? 1'b0 : mRdErr);
            checkOutput("cpuXferGnt", cpuXferGnt, eGnt);
            checkOutput("DIAG_DIAG", DIAG_DIAG, eDiag);
            checkOutput("funcGrp", funcGrp, eGrp);
            checkOutput("DIAG_STROBE", DIAG_STROBE, eStrobe);
            checkOutput("DIAG_READ", DIAG_READ, eRead);
            checkOutput("EBUS_XFER", EBUS_XFER, eXfer);
            checkOutput("EBUS_T_TO_E_EN", EBUS_T_TO_E_EN, eTtoE);
            checkOutput("EBUS_E_TO_T_EN", EBUS_E_TO_T_EN, eRead);
            checkOutput("ebusDataOut", ebusDataOut, eDout);
            checkOutput("EBUS_PARITY_OUT", EBUS_PARITY_OUT, ePar);
            checkOutput("busConflict", EBUS_T_TO_E_EN & EBUS_E_TO_T_EN, 0);

            if (reqAck) begin ackCount++; lastAckCyc = cycleNo; end
            if (done) begin doneCount++; lastDoneCyc = cycleNo; end
            if (DIAG_STROBE) begin strobeCount++; lastStrobeCyc = cycleNo; end
            if (DIAG_READ) readHigh++;
            if (cpuXferGnt) gntCount++;
            if (cycleNo == lastAckCyc + 1) begin
                grpAtSetup  = funcGrp;
                doutAtSetup = ebusDataOut;
            end

            if (CROBAR) begin
                mMode = 0; mK = 0; mFair = 0; mRdata = '0; mRdErr = 0;
            end else begin
                case (mMode)
                    0: begin
                        if (eAck) begin
                            mMode = 2; mK = 1; mRead = reqFunc[0];
                            mFunc = reqFunc; mData = reqWdata; mFair = 0;
                        end else if (cpuXferReq) begin
                            mMode = 1;
                        end
                    end
                    1: if (!cpuXferReq) begin mMode = 0; mFair = 1; end
                    default: begin
                        len = mRead ? RW + 3 : 4;
                        if (mRead && mK == RW + 2) begin
                            mRdata = ebusDataIn;
`ifdef EBUS_PARITY_EN
                            mRdErr = (ebusParityIn != expParity(ebusDataIn));
`else
                            mRdErr = 1'b0;
`endif
                        end
                        mK++;
                        if (mK > len) mMode = 0;
                    end
                endcase
            end
        end
    end

    // Drive a diag request and/or a CPU transfer; returns after done and after cpuCycles of CPU request
    task automatic applyStimulus(input bit doReq, input logic [0:6] f, input logic [35:0] d,
                                 input int cpuCycles);
        int cyc;
        bit acked;
        bit finished;
        @(posedge clk); #1;
        if (doReq) begin
            reqFunc  = f;
            reqWdata = d;
            req      = 1'b1;
        end
        cpuXferReq = (cpuCycles > 0);
        acked    = !doReq;
        finished = !doReq;
        cyc      = 0;
        while ((!acked || !finished || cyc < cpuCycles) && cyc < 200) begin
            @(negedge clk);
            if (req && reqAck) acked = 1;
            else if (acked && doReq && done) finished = 1;
            @(posedge clk); #1;
            cyc++;
            if (acked && req) begin
                req      = 1'b0;
                reqFunc  = 7'($urandom);
                reqWdata = 36'($urandom);
            end
            if (cpuXferReq && cyc >= cpuCycles) begin
                cpuXferReq  = 1'b0;
                lastDropCyc = cycleNo + 1;
            end
        end
        if (cyc >= 200) checkOutput("transactionTimeout", 1, 0);
        req        = 1'b0;
        cpuXferReq = 1'b0;
    endtask

    initial begin : mainProc
        int snapStrobe, snapRead, snapGnt, snapDone, snapAck, reqIssued;
        bit acked;
        logic [63:0] rnd;
        CROBAR = 1'b1; req = 1'b0; reqFunc = '0; reqWdata = '0;
        cpuXferReq = 1'b0; ebusDataIn = '0; ebusParityIn = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetDone", done, 0);
        checkOutput("resetDiag", DIAG_DIAG, 0);
        checkOutput("resetXfer", EBUS_XFER, 0);
        checkOutput("resetRdata", rdata, 0);
        CROBAR = 1'b0;
        $display("[TB] reset released");

        // Write 072
        snapStrobe = strobeCount;
        applyStimulus(1, 7'o072, 36'o123456765432, 0);
        checkOutput("wrLatency", lastDoneCyc - lastAckCyc, 4);
        checkOutput("wrStrobeAt", lastStrobeCyc - lastAckCyc, 2);
        checkOutput("wrStrobeCount", strobeCount - snapStrobe, 1);
        checkOutput("wrFuncGrp", grpAtSetup, 16'h0080);
        checkOutput("wrDataOut", doutAtSetup, 36'o123456765432);

        // Read 131 with correct parity
        ebusDataIn   = 36'o777000000777;
        ebusParityIn = 1'b1;
        snapRead = readHigh;
        applyStimulus(1, 7'o131, 36'd0, 0);
        checkOutput("rdLatency", lastDoneCyc - lastAckCyc, 7);
        checkOutput("rdData", rdata, 36'o777000000777);
        checkOutput("rdReadCycles", readHigh - snapRead, 6);
        checkOutput("rdFuncGrp", grpAtSetup, 16'h0800);
        checkOutput("rdErrGood", rdErr, 0);

        // Same read, wrong parity
        ebusParityIn = 1'b0;
        applyStimulus(1, 7'o131, 36'd0, 0);
`ifdef EBUS_PARITY_EN
        checkOutput("rdErrBad", rdErr, 1);
`else
        checkOutput("rdErrBad", rdErr, 0);
`endif

        // CPU and diag request together with the fairness flag clear
        snapGnt = gntCount;
        applyStimulus(1, 7'o040, 36'o1, 3);
        checkOutput("cpuGntCycles", gntCount - snapGnt, 3);
        checkOutput("ackAfterCpu", ((lastAckCyc - lastDropCyc) inside {[1:2]}) ? 1 : 0, 1);

        // Reset during RWAIT
        @(posedge clk); #1;
        reqFunc = 7'o131; req = 1'b1;
        acked = 0;
        for (int i = 0; i < 20 && !acked; i++) begin
            @(negedge clk);
            acked = reqAck;
            @(posedge clk); #1;
        end
        req = 1'b0;
        checkOutput("rstAcked", acked, 1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstInRwait", DIAG_READ, 1);
        CROBAR = 1'b1;
        #1;
        checkOutput("rstRead", DIAG_READ, 0);
        checkOutput("rstXfer", EBUS_XFER, 0);
        checkOutput("rstEtoT", EBUS_E_TO_T_EN, 0);
        checkOutput("rstDiag", DIAG_DIAG, 0);
        checkOutput("rstGrp", funcGrp, 0);
        checkOutput("rstRdata", rdata, 0);
        snapDone = doneCount;
        @(posedge clk); #1;
        CROBAR = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("noDoneAfterReset", doneCount - snapDone, 0);
        applyStimulus(1, 7'o131, 36'd0, 0);
        checkOutput("postResetLatency", lastDoneCyc - lastAckCyc, 7);

        // Random mix of read, write and CPU transfers
        snapAck   = ackCount;
        snapDone  = doneCount;
        reqIssued = 0;
        for (int n = 0; n < 1000; n++) begin
            int kind;
            logic [0:6] f;
            kind = $urandom_range(0, 3);
            rnd  = {$urandom, $urandom};
            ebusDataIn   = rnd[35:0];
            ebusParityIn = 1'($urandom);
            rnd  = {$urandom, $urandom};
            f    = 7'($urandom_range(0, 127));
            case (kind)
                0: begin f[0] = 1'b0; applyStimulus(1, f, rnd[35:0], 0); reqIssued++; end
                1: begin f[0] = 1'b1; applyStimulus(1, f, rnd[35:0], 0); reqIssued++; end
                2: applyStimulus(0, f, rnd[35:0], $urandom_range(1, 4));
                default: begin applyStimulus(1, f, rnd[35:0], $urandom_range(1, 4)); reqIssued++; end
            endcase
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("randomAcks", ackCount - snapAck, reqIssued);
        checkOutput("randomDones", doneCount - snapDone, reqIssued);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
